// File: rtl/pong_pixel_gen_if.sv
// Signal bundle between the VGA driver / game inputs and the pong engine.
// dbg_* fields mirror internal game state so external checkers can observe it.
interface pong_pixel_gen_if;
  logic [9:0] pixel_row;
  logic [9:0] pixel_col;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic       serve;
  logic [2:0] pixel_rgb;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       game_over;
  logic [1:0] dbg_state;
  logic [9:0] dbg_ball_x;
  logic [9:0] dbg_ball_y;
  logic       dbg_dx_neg;
  logic       dbg_dy_neg;
  logic [9:0] dbg_p1_y;
  logic [9:0] dbg_p2_y;

  modport master (
    output pixel_row, pixel_col, p1_up, p1_down, p2_up, p2_down, serve,
    input  pixel_rgb, score_p1, score_p2, game_over,
    input  dbg_state, dbg_ball_x, dbg_ball_y, dbg_dx_neg, dbg_dy_neg, dbg_p1_y, dbg_p2_y
  );

  modport slave (
    input  pixel_row, pixel_col, p1_up, p1_down, p2_up, p2_down, serve,
    output pixel_rgb, score_p1, score_p2, game_over,
    output dbg_state, dbg_ball_x, dbg_ball_y, dbg_dx_neg, dbg_dy_neg, dbg_p1_y, dbg_p2_y
  );
endinterface

// File: rtl/pong_pixel_gen.sv
// Pong game engine: per-frame ball/paddle update, scoring FSM and a
// zero-latency pixel renderer feeding the VGA driver.
module pong_pixel_gen #(
  parameter int HACTIVE      = 640,
  parameter int VACTIVE      = 480,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_X1    = 16,
  parameter int PADDLE_X2    = 616,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int WIN_SCORE    = 9,
  parameter int POINT_PAUSE  = 60
) (
  input logic             clock,
  input logic             reset,
  pong_pixel_gen_if.slave bus
);
  localparam logic [9:0] HA      = 10'(HACTIVE);
  localparam logic [9:0] VA      = 10'(VACTIVE);
  localparam logic [9:0] BS      = 10'(BALL_SIZE);
  localparam logic [9:0] SP      = 10'(BALL_SPEED);
  localparam logic [9:0] PS      = 10'(PADDLE_SPEED);
  localparam logic [9:0] PH      = 10'(PADDLE_H);
  localparam logic [9:0] PW      = 10'(PADDLE_W);
  localparam logic [9:0] PX1     = 10'(PADDLE_X1);
  localparam logic [9:0] PX2     = 10'(PADDLE_X2);
  localparam logic [9:0] P_MAX   = 10'(VACTIVE - PADDLE_H);
  localparam logic [9:0] Y_MAX   = 10'(VACTIVE - BALL_SIZE);
  localparam logic [9:0] L_PLANE = 10'(PADDLE_X1 + PADDLE_W);
  localparam logic [9:0] R_PLANE = 10'(PADDLE_X2 - BALL_SIZE);
  localparam logic [9:0] BX0     = 10'(HACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] BY0     = 10'(VACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] PY0     = 10'((VACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] NET_L   = 10'(HACTIVE / 2 - 2);
  localparam logic [9:0] NET_R   = 10'(HACTIVE / 2 + 2);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [7:0] PAUSE_LAST = 8'(POINT_PAUSE - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PLAY     = 2'd1,
    S_POINT    = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;

  state_t     state;
  logic [9:0] ball_x, ball_y, p1_y, p2_y;
  logic       dx_neg, dy_neg;
  logic [3:0] score_p1, score_p2;
  logic       game_over;
  logic [7:0] pause_cnt;

  logic       frame_tick;
  logic [9:0] bx_next, by_next;
  logic       dx_next, dy_next;
  logic       miss_l, miss_r;
  logic       overlap1, overlap2;
  logic [3:0] score_inc;

  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up,
                                             input logic down);
    paddle_step = y;
    if (up && !down)      paddle_step = (y < PS) ? '0 : y - PS;
    else if (down && !up) paddle_step = (y > P_MAX - PS) ? P_MAX : y + PS;
  endfunction

  assign frame_tick = (bus.pixel_row == VA) && (bus.pixel_col == '0);

  // Next ball position; collision tests use the paddle positions before this tick.
  always_comb begin
    by_next  = ball_y;
    dy_next  = dy_neg;
    bx_next  = ball_x;
    dx_next  = dx_neg;
    miss_l   = 1'b0;
    miss_r   = 1'b0;
    overlap1 = (ball_y + BS > p1_y) && (ball_y < p1_y + PH);
    overlap2 = (ball_y + BS > p2_y) && (ball_y < p2_y + PH);

    if (dy_neg) begin
      if (ball_y < SP) begin
        by_next = '0;
        dy_next = 1'b0;
      end else begin
        by_next = ball_y - SP;
      end
    end else begin
      if (ball_y + BS + SP > VA) begin
        by_next = Y_MAX;
        dy_next = 1'b1;
      end else begin
        by_next = ball_y + SP;
      end
    end

    if (dx_neg) begin
      if (ball_x >= L_PLANE && ball_x - SP <= L_PLANE && overlap1) begin
        bx_next = L_PLANE;
        dx_next = 1'b0;
      end else if (ball_x < SP) begin
        miss_l = 1'b1;
      end else begin
        bx_next = ball_x - SP;
      end
    end else begin
      if (ball_x <= R_PLANE && ball_x + SP >= R_PLANE && overlap2) begin
        bx_next = R_PLANE;
        dx_next = 1'b1;
      end else if (ball_x + BS + SP > HA) begin
        miss_r = 1'b1;
      end else begin
        bx_next = ball_x + SP;
      end
    end

    score_inc = miss_r ? score_p1 : score_p2;
    if (score_inc != 4'hF) score_inc = score_inc + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      ball_x    <= BX0;
      ball_y    <= BY0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      p1_y      <= PY0;
      p2_y      <= PY0;
      score_p1  <= '0;
      score_p2  <= '0;
      game_over <= 1'b0;
      pause_cnt <= '0;
    end else begin
      if (frame_tick && state != S_GAMEOVER) begin
        p1_y <= paddle_step(p1_y, bus.p1_up, bus.p1_down);
        p2_y <= paddle_step(p2_y, bus.p2_up, bus.p2_down);
      end
      case (state)
        S_IDLE: begin
          if (frame_tick && bus.serve) begin
            state  <= S_PLAY;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            if (miss_l || miss_r) begin
              if (miss_r) score_p1 <= score_inc;
              else        score_p2 <= score_inc;
              if (score_inc == WIN) begin
                state     <= S_GAMEOVER;
                game_over <= 1'b1;
              end else begin
                // Re-serve toward whoever just conceded; dy carries over.
                state     <= S_POINT;
                ball_x    <= BX0;
                ball_y    <= BY0;
                pause_cnt <= '0;
                dx_neg    <= miss_l;
              end
            end else begin
              ball_x <= bx_next;
              ball_y <= by_next;
              dx_neg <= dx_next;
              dy_neg <= dy_next;
            end
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            if (pause_cnt == PAUSE_LAST) state <= S_PLAY;
            else                         pause_cnt <= pause_cnt + 8'd1;
          end
        end
        S_GAMEOVER: begin
          if (bus.serve) begin
            state     <= S_IDLE;
            score_p1  <= '0;
            score_p2  <= '0;
            game_over <= 1'b0;
            ball_x    <= BX0;
            ball_y    <= BY0;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  logic in_ball, in_p1, in_p2, in_net, visible;

  always_comb begin
    visible = (bus.pixel_row < VA) && (bus.pixel_col < HA);
    in_ball = (state != S_GAMEOVER) &&
              (bus.pixel_col >= ball_x) && (bus.pixel_col < ball_x + BS) &&
              (bus.pixel_row >= ball_y) && (bus.pixel_row < ball_y + BS);
    in_p1   = (bus.pixel_col >= PX1) && (bus.pixel_col < PX1 + PW) &&
              (bus.pixel_row >= p1_y) && (bus.pixel_row < p1_y + PH);
    in_p2   = (bus.pixel_col >= PX2) && (bus.pixel_col < PX2 + PW) &&
              (bus.pixel_row >= p2_y) && (bus.pixel_row < p2_y + PH);
    in_net  = (bus.pixel_col >= NET_L) && (bus.pixel_col < NET_R) && !bus.pixel_row[4];
    bus.pixel_rgb = 3'b000;
    if (visible) begin
      if (in_ball)     bus.pixel_rgb = 3'b111;
      else if (in_p1)  bus.pixel_rgb = 3'b100;
      else if (in_p2)  bus.pixel_rgb = 3'b001;
      else if (in_net) bus.pixel_rgb = 3'b010;
    end
  end

  assign bus.score_p1   = score_p1;
  assign bus.score_p2   = score_p2;
  assign bus.game_over  = game_over;
  assign bus.dbg_state  = state;
  assign bus.dbg_ball_x = ball_x;
  assign bus.dbg_ball_y = ball_y;
  assign bus.dbg_dx_neg = dx_neg;
  assign bus.dbg_dy_neg = dy_neg;
  assign bus.dbg_p1_y   = p1_y;
  assign bus.dbg_p2_y   = p2_y;
endmodule
